// File: rtl/oled_pkg.sv
// Shared panel definitions: SSD1351-style opcodes, flush FSM states and
// the fixed window/write header used before every framebuffer flush.
package oled_pkg;

  localparam logic [7:0] CMD_SET_COL   = 8'h15;
  localparam logic [7:0] CMD_SET_ROW   = 8'h75;
  localparam logic [7:0] CMD_WRITE_RAM = 8'h5C;
  localparam logic [2:0] HDR_LAST      = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_LATCH,
    S_HDR_SEND,
    S_FETCH,
    S_HI_LATCH,
    S_HI_SEND,
    S_LO_LATCH,
    S_LO_SEND,
    S_DONE
  } state_t;

  // {dc, byte}; dc=0 marks a command byte
  function automatic logic [8:0] hdr_byte(
    input logic [2:0] idx,
    input logic [7:0] col_end,
    input logic [7:0] row_end
  );
    logic [8:0] b;
    case (idx)
      3'd0:    b = {1'b0, CMD_SET_COL};
      3'd1:    b = {1'b1, 8'h00};
      3'd2:    b = {1'b1, col_end};
      3'd3:    b = {1'b0, CMD_SET_ROW};
      3'd4:    b = {1'b1, 8'h00};
      3'd5:    b = {1'b1, row_end};
      3'd6:    b = {1'b0, CMD_WRITE_RAM};
      default: b = 9'h000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_fb_flush_if.sv
// Flush control, framebuffer read port and 6800-style panel bus.
// master = flush engine, slave = controller/framebuffer/panel side.
interface oled_fb_flush_if #(
  parameter int ADDR_W = 14
);
  logic              init_done;
  logic              start;
  logic              busy;
  logic              done;
  logic              fb_rd;
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0]       fb_data;
  logic              oled_cs;
  logic              oled_e;
  logic              oled_rw;
  logic              oled_dc;
  logic [7:0]        oled_dout;

  modport master (
    input  init_done, start, fb_data,
    output busy, done, fb_rd, fb_addr,
    output oled_cs, oled_e, oled_rw, oled_dc, oled_dout
  );

  modport slave (
    output init_done, start, fb_data,
    input  busy, done, fb_rd, fb_addr,
    input  oled_cs, oled_e, oled_rw, oled_dc, oled_dout
  );
endinterface

// File: rtl/oled_fb_flush.sv
// Streams a full RGB565 framebuffer to the panel: window header, then
// two bytes per pixel, each byte written on the falling edge of oled_e.
module oled_fb_flush
  import oled_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int ROWS   = 128,
  parameter int ADDR_W = 14
) (
  input  logic clk,
  input  logic rst,
  oled_fb_flush_if.master bus
);

  localparam int NPIX = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  localparam logic [7:0] COL_END = 8'(COLS - 1);
  localparam logic [7:0] ROW_END = 8'(ROWS - 1);

  state_t            r_state;
  logic [2:0]        r_hidx;
  logic [ADDR_W-1:0] r_pix;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_lo;
  logic [7:0]        r_dout;
  logic              r_cs;
  logic              r_e;
  logic              r_dc;
  logic              r_busy;
  logic              r_done;
  logic              r_rd;

  logic [8:0] w_hdr0;
  logic [8:0] w_hdr_nxt;

  assign w_hdr0    = hdr_byte(3'd0, COL_END, ROW_END);
  assign w_hdr_nxt = hdr_byte(r_hidx + 3'd1, COL_END, ROW_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hidx  <= '0;
      r_pix   <= '0;
      r_addr  <= '0;
      r_lo    <= '0;
      r_dout  <= '0;
      r_cs    <= 1'b1;
      r_e     <= 1'b1;
      r_dc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && bus.init_done) begin
            r_state       <= S_HDR_LATCH;
            r_cs          <= 1'b0;
            r_busy        <= 1'b1;
            r_hidx        <= '0;
            r_pix         <= '0;
            {r_dc, r_dout} <= w_hdr0;
            r_e           <= 1'b1;
          end
        end
        S_HDR_LATCH: begin
          r_e     <= 1'b0;
          r_state <= S_HDR_SEND;
        end
        S_HDR_SEND: begin
          r_hidx <= r_hidx + 3'd1;
          if (r_hidx == HDR_LAST) begin
            r_state <= S_FETCH;
            r_rd    <= 1'b1;
            r_addr  <= r_pix;
          end else begin
            r_state        <= S_HDR_LATCH;
            {r_dc, r_dout} <= w_hdr_nxt;
            r_e            <= 1'b1;
          end
        end
        S_FETCH: begin
          r_rd    <= 1'b0;
          r_e     <= 1'b1;
          r_dc    <= 1'b1;
          r_state <= S_HI_LATCH;
        end
        // high byte goes out combinationally this cycle, then is held
        S_HI_LATCH: begin
          r_lo    <= bus.fb_data[7:0];
          r_dout  <= bus.fb_data[15:8];
          r_e     <= 1'b0;
          r_state <= S_HI_SEND;
        end
        S_HI_SEND: begin
          r_dout  <= r_lo;
          r_e     <= 1'b1;
          r_state <= S_LO_LATCH;
        end
        S_LO_LATCH: begin
          r_e     <= 1'b0;
          r_state <= S_LO_SEND;
        end
        S_LO_SEND: begin
          if (r_pix == LAST) begin
            r_state <= S_DONE;
            r_cs    <= 1'b1;
            r_e     <= 1'b1;
            r_dc    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_pix   <= r_pix + ADDR_W'(1);
            r_addr  <= r_pix + ADDR_W'(1);
            r_rd    <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_dout  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oled_dout = (r_state == S_HI_LATCH) ? bus.fb_data[15:8]
                                                 : r_dout;
  assign bus.oled_cs   = r_cs;
  assign bus.oled_e    = r_e;
  assign bus.oled_dc   = r_dc;
  assign bus.oled_rw   = 1'b0;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fb_rd     = r_rd;
  assign bus.fb_addr   = r_addr;

endmodule

// File: tb/tb_oled_fb_flush.sv
// Scoreboard bench for oled_fb_flush on a 4x2 panel with a random
// one-cycle-latency framebuffer.
module tb_oled_fb_flush;

  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int ADDR_W = 14;
  localparam int NPIX   = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oled_fb_flush_if #(.ADDR_W(ADDR_W)) bus();

  oled_fb_flush #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mem [NPIX];

  always @(posedge clk)
    if (bus.fb_rd) bus.fb_data <= mem[bus.fb_addr[2:0]];

  int vec = 0;
  int err = 0;
  logic [8:0]        exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  int done_cnt = 0;
  int fall_cnt = 0;
  int rw_bad   = 0;
  int cyc      = 0;
  int t_busy   = 0;
  logic       p_e    = 1'b1;
  logic       p_dc   = 1'b0;
  logic       p_busy = 1'b0;
  logic [7:0] p_dout = 8'h00;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // monitor: every panel write and framebuffer read is checked in order
  always @(negedge clk) begin
    cyc++;
    if (bus.oled_rw !== 1'b0) rw_bad++;
    if (rst) begin
      p_e    = 1'b1;
      p_busy = 1'b0;
    end else begin
      if (p_e && bus.oled_e === 1'b0) begin
        fall_cnt++;
        chk("cs_low_on_write", 32'(bus.oled_cs), 32'd0);
        if (exp_q.size() == 0) begin
          vec++; err++;
          $display("FAIL extra_byte: got %0h expected none", {p_dc, p_dout});
        end else
          chk("byte", 32'({p_dc, p_dout}), 32'(exp_q.pop_front()));
      end
      if (bus.fb_rd === 1'b1) begin
        if (addr_q.size() == 0) begin
          vec++; err++;
          $display("FAIL extra_fb_rd: got %0h expected none", bus.fb_addr);
        end else
          chk("fb_addr", 32'(bus.fb_addr), 32'(addr_q.pop_front()));
      end
      if (bus.busy && !p_busy) t_busy = cyc;
      if (bus.done === 1'b1) begin
        done_cnt++;
        chk("flush_cycles", 32'(cyc - t_busy), 32'd54);
      end
      p_e    = bus.oled_e;
      p_dc   = bus.oled_dc;
      p_dout = bus.oled_dout;
      p_busy = bus.busy;
    end
  end

  // reference: window header then hi/lo bytes of every pixel in order
  task automatic push_flush();
    logic [8:0] hdr [7];
    hdr[0] = {1'b0, 8'h15};
    hdr[1] = {1'b1, 8'h00};
    hdr[2] = {1'b1, 8'(COLS - 1)};
    hdr[3] = {1'b0, 8'h75};
    hdr[4] = {1'b1, 8'h00};
    hdr[5] = {1'b1, 8'(ROWS - 1)};
    hdr[6] = {1'b0, 8'h5C};
    for (int i = 0; i < 7; i++) exp_q.push_back(hdr[i]);
    for (int a = 0; a < NPIX; a++) begin
      exp_q.push_back({1'b1, mem[a][15:8]});
      exp_q.push_back({1'b1, mem[a][7:0]});
      addr_q.push_back(ADDR_W'(a));
    end
  endtask

  task automatic rand_mem();
    for (int a = 0; a < NPIX; a++) mem[a] = 16'($urandom);
  endtask

  task automatic do_flush(input bit spam);
    int f0;
    int d0;
    bit got;
    f0  = fall_cnt;
    d0  = done_cnt;
    got = 1'b0;
    push_flush();
    @(negedge clk) bus.start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!spam) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      vec++; err++;
      $display("FAIL done_timeout: got none expected pulse");
      exp_q.delete();
      addr_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("write_edges", 32'(fall_cnt - f0), 32'd23);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("queue_left", 32'(exp_q.size() + addr_q.size()), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("cs_parked", 32'(bus.oled_cs), 32'd1);
  endtask

  task automatic idle_start();
    int f0;
    int d0;
    f0 = fall_cnt;
    d0 = done_cnt;
    bus.init_done = 1'b0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("noinit_edges", 32'(fall_cnt - f0), 32'd0);
    chk("noinit_busy", 32'(bus.busy), 32'd0);
    chk("noinit_cs", 32'(bus.oled_cs), 32'd1);
    chk("noinit_done", 32'(done_cnt - d0), 32'd0);
    bus.init_done = 1'b1;
  endtask

  task automatic reset_mid();
    int d0;
    bit hit;
    d0  = done_cnt;
    hit = 1'b0;
    rand_mem();
    push_flush();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.fb_rd === 1'b1 && bus.fb_addr == ADDR_W'(3)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) begin
      vec++; err++;
      $display("FAIL pix3_timeout: got none expected fb_rd addr 3");
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_cs", 32'(bus.oled_cs), 32'd1);
    chk("rst_e", 32'(bus.oled_e), 32'd1);
    chk("rst_fb_rd", 32'(bus.fb_rd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dout", 32'(bus.oled_dout), 32'd0);
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (10) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
  endtask

  initial begin
    bus.init_done = 1'b1;
    bus.start     = 1'b0;
    for (int a = 0; a < NPIX; a++) mem[a] = 16'hA000 | 16'(a);
    repeat (2) @(negedge clk);
    chk("reset_cs", 32'(bus.oled_cs), 32'd1);
    chk("reset_e", 32'(bus.oled_e), 32'd1);
    chk("reset_dc", 32'(bus.oled_dc), 32'd0);
    chk("reset_dout", 32'(bus.oled_dout), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_fb_rd", 32'(bus.fb_rd), 32'd0);
    chk("reset_fb_addr", 32'(bus.fb_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_flush(1'b0);
    idle_start();
    rand_mem();
    do_flush(1'b1);
    reset_mid();
    rand_mem();
    do_flush(1'b0);

    rand_mem();
    fork
      do_flush(1'b0);
      begin
        repeat (20) @(negedge clk);
        bus.init_done = 1'b0;
      end
    join
    bus.init_done = 1'b1;

    for (int k = 0; k < 4; k++) begin
      rand_mem();
      repeat ($urandom_range(0, 6)) @(negedge clk);
      do_flush(1'($urandom_range(0, 1)));
    end

    chk("rw_always_0", 32'(rw_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/oled_fb_flush.md
OLED_FB_FLUSH -- requirements
Module: oled_fb_flush

Interface
REQ-001 SHALL have parameter COLS, default 128, display width in pixels.
REQ-002 SHALL have parameter ROWS, default 128, display height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 14, framebuffer address width; COLS*ROWS SHALL be at most 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port init_done, input, 1, high once the panel init sequence is complete.
REQ-007 SHALL have port start, input, 1, single-cycle flush request.
REQ-008 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-009 SHALL have port done, output, 1, single-cycle pulse when a flush completes.
REQ-010 SHALL have port fb_rd, output, 1, framebuffer read strobe.
REQ-011 SHALL have port fb_addr, output, ADDR_W, pixel index (row*COLS+col).
REQ-012 SHALL have port fb_data, input, 16, RGB565 pixel, valid in the cycle after fb_rd.
REQ-013 SHALL have ports oled_cs, oled_e, oled_rw, oled_dc (each output, 1) and oled_dout (output, 8), a 6800-style parallel panel bus.

Function
REQ-014 SHALL accept start only in IDLE with init_done=1; otherwise start SHALL be ignored, not queued.
REQ-015 SHALL have states IDLE, HDR_LATCH, HDR_SEND, FETCH, HI_LATCH, HI_SEND, LO_LATCH, LO_SEND, DONE.
REQ-016 On accepted start, SHALL set oled_cs=0, busy=1, header index 0, pixel counter 0, and go to HDR_LATCH.
REQ-017 Header bytes SHALL be, in order: 15h(cmd) 00h COLS-1, 75h(cmd) 00h ROWS-1, 5Ch(cmd); oled_dc=0 for cmd bytes and 1 for data bytes.
REQ-018 Each bus byte SHALL take two cycles: LATCH drives oled_dout, oled_dc and oled_e=1; SEND drives oled_e=0. The panel write is the falling edge of oled_e.
REQ-019 HDR_SEND SHALL increment the header index, then go to FETCH after index 6, otherwise to HDR_LATCH.
REQ-020 FETCH SHALL assert fb_rd=1 for exactly one cycle with fb_addr = pixel counter; fb_rd SHALL be 0 in all other states.
REQ-021 HI_LATCH SHALL drive oled_dout=fb_data[15:8] and register fb_data[7:0]; LO_LATCH SHALL drive the registered low byte; both SHALL use oled_dc=1.
REQ-022 Each pixel SHALL take exactly 5 cycles: FETCH, HI_LATCH, HI_SEND, LO_LATCH, LO_SEND.
REQ-023 LO_SEND SHALL go to DONE when pixel counter = COLS*ROWS-1; otherwise it SHALL increment the counter and go to FETCH.
REQ-024 DONE SHALL set oled_cs=1 and oled_e=1, pulse done=1 for one cycle, clear busy, and return to IDLE.
REQ-025 A flush SHALL emit exactly 7 + 2*COLS*ROWS bytes and span 14 + 5*COLS*ROWS cycles between HDR_LATCH entry and DONE entry.
REQ-026 oled_rw SHALL be 0 at all times.
REQ-027 In IDLE the bus SHALL be parked at cs=1, e=1, dc=0, so an external mux can select the init sequencer or this block by cs.
REQ-028 init_done falling mid-flush SHALL NOT abort the flush.
REQ-029 start asserted while busy SHALL have no effect on the counters or the byte sequence.

Reset
REQ-030 rst SHALL force IDLE immediately with oled_cs=1, oled_e=1, oled_rw=0, oled_dc=0, oled_dout=00h, busy=0, done=0, fb_rd=0, fb_addr=0, and the counters cleared.
REQ-031 rst mid-flush SHALL abandon the flush with no done pulse; the next accepted start SHALL restart from the first header byte.

Structure
REQ-032 Opcodes CMD_SET_COL=15h, CMD_SET_ROW=75h and CMD_WRITE_RAM=5Ch SHALL live in shared package oled_pkg, which is also used by the init sequencer.
REQ-033 The header SHALL be a combinational function of the header index; no ROM file SHALL be used.
REQ-034 No sub-module is required; the bus byte engine SHALL stay inline in the FSM.

Verification (COLS=4, ROWS=2, fb model returns 16'hA000|addr, one-cycle latency)
REQ-035 init_done=1, start pulse -> bytes 15 00 03 75 00 01 5C with dc 0,1,1,0,1,1,0, then A0 00 A0 01 ... A0 07 with dc=1; 23 falling edges of oled_e; done one pulse; 54 cycles from HDR_LATCH entry to DONE entry.
REQ-036 start with init_done=0 -> no bus activity; cs stays 1, busy stays 0, no done pulse.
REQ-037 start re-pulsed every cycle during a flush -> byte stream identical to REQ-035; exactly one done pulse.
REQ-038 rst asserted during pixel 3 HI_SEND -> same cycle cs=1, e=1, fb_rd=0, busy=0; no done pulse; next start replays from the 15h byte.
REQ-039 Throughout every test -> fb_rd high exactly 8 cycles per flush with fb_addr 0..7 ascending; oled_rw always 0.
